mips_cache_controller_param: RTL and testbench

Parametrised direct-mapped, write-through, no-write-allocate cache controller between the MIPS CPU data port (Avalon-MM slave side) and the memory bus (Avalon-MM master side). It succeeds the fixed single-configuration controller. Line count and words per line are generic. Misses trigger multi-word line fills, and the block adds a whole-cache invalidate. It sits between mips_cpu and the memory/bus interconnect.

---
 rtl/mips_cache_controller_param.sv | 225 ++++++++++++++++++++++
 tb/tb_mips_cache_controller_param.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/mips_cache_controller_param.sv
// Direct-mapped write-through, no-write-allocate cache between the MIPS data port and the memory bus; read hits take zero wait states.
// The CPU is stalled through cpu_waitrequest during line fills and memory writes; defining CACHE_STATS_EN adds hit/miss/write counters.
module mips_cache_controller_param #(
  parameter int LINES          = 16,
  parameter int WORDS_PER_LINE = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] cpu_address,
  input  logic        cpu_read,
  input  logic        cpu_write,
  input  logic [31:0] cpu_writedata,
  input  logic [3:0]  cpu_byteenable,
  output logic        cpu_waitrequest,
  output logic [31:0] cpu_readdata,
  input  logic        invalidate,
  output logic [31:0] address,
  output logic        write,
  output logic        read,
  output logic [31:0] writedata,
  output logic [3:0]  byteenable,
  input  logic        waitrequest,
  input  logic [31:0] readdata
`ifdef CACHE_STATS_EN
  ,
  output logic [31:0] stat_hits,
  output logic [31:0] stat_misses,
  output logic [31:0] stat_writes
`endif
);

  localparam int IW  = $clog2(LINES);
  localparam int OW  = $clog2(WORDS_PER_LINE);
  localparam int OWX = (OW > 0) ? OW : 1;
  localparam int TW  = 30 - OW - IW;
  localparam int FW  = IW + OW;
  localparam int NW  = LINES * WORDS_PER_LINE;

  typedef enum logic [1:0] {
    STATE_IDLE  = 2'd0,
    STATE_WRITE = 2'd1,
    STATE_FETCH = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [OWX-1:0]   cnt_q, cnt_d;
  logic [LINES-1:0] valid_q, valid_d;
  logic             inv_pend_q, inv_pend_d;

  logic [TW-1:0]    tag_q  [LINES];
  logic [31:0]      data_q [NW];

  logic [TW-1:0]    req_tag;
  logic [IW-1:0]    req_idx;
  logic [FW-1:0]    word_ptr;
  logic [FW-1:0]    fill_ptr;
  logic [31:0]      fetch_addr;
  logic             line_hit;
  logic             last_word;
  logic             fill_beat;
  logic             fill_done;
  logic             wr_done;
  logic             to_idle;
  logic             idle_rd_hit;
  logic             addr_lsb_unused;

  assign addr_lsb_unused = ^cpu_address[1:0];

  // index and offset are contiguous, so the flat word pointer is a plain slice
  assign req_tag    = cpu_address[31 -: TW];
  assign req_idx    = cpu_address[2+OW +: IW];
  assign word_ptr   = cpu_address[2 +: FW];
  assign fill_ptr   = (FW'(req_idx) << OW) | FW'(cnt_q);
  assign fetch_addr = {cpu_address[31:2+OW], {(OW+2){1'b0}}} | (32'(cnt_q) << 2);

  assign line_hit    = valid_q[req_idx] && (tag_q[req_idx] == req_tag);
  assign last_word   = (cnt_q == OWX'(WORDS_PER_LINE - 1));
  assign fill_beat   = (state_q == STATE_FETCH) && !waitrequest;
  assign fill_done   = fill_beat && last_word;
  assign wr_done     = (state_q == STATE_WRITE) && !waitrequest;
  assign to_idle     = fill_done || wr_done;
  // an invalidate in the same cycle forces the lookup to miss
  assign idle_rd_hit = (state_q == STATE_IDLE) && cpu_read && !cpu_write &&
                       line_hit && !invalidate;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= STATE_IDLE;
      cnt_q      <= '0;
      valid_q    <= '0;
      inv_pend_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      valid_q    <= valid_d;
      inv_pend_q <= inv_pend_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      STATE_IDLE: begin
        cnt_d = '0;
        if (cpu_write) begin
          state_d = STATE_WRITE;
        end else if (cpu_read && !idle_rd_hit) begin
          state_d = STATE_FETCH;
        end
      end
      STATE_FETCH: begin
        if (!waitrequest) begin
          cnt_d = cnt_q + OWX'(1);
          if (last_word) begin
            state_d = STATE_IDLE;
          end
        end
      end
      STATE_WRITE: begin
        if (!waitrequest) begin
          state_d = STATE_IDLE;
        end
      end
      default: state_d = STATE_IDLE;
    endcase
  end

  // a pending invalidate lands on the same edge that returns to IDLE, so it
  // also wipes the line that fill is just completing
  always_comb begin
    valid_d    = valid_q;
    inv_pend_d = inv_pend_q;
    if (fill_done) begin
      valid_d[req_idx] = 1'b1;
    end
    if (state_q == STATE_IDLE) begin
      inv_pend_d = 1'b0;
      if (invalidate) begin
        valid_d = '0;
      end
    end else if (to_idle) begin
      inv_pend_d = 1'b0;
      if (inv_pend_q || invalidate) begin
        valid_d = '0;
      end
    end else if (invalidate) begin
      inv_pend_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (fill_beat) begin
      data_q[fill_ptr] <= readdata;
    end
    if (fill_done) begin
      tag_q[req_idx] <= req_tag;
    end
    if (wr_done && line_hit) begin
      for (int b = 0; b < 4; b++) begin
        if (cpu_byteenable[b]) begin
          data_q[word_ptr][8*b +: 8] <= cpu_writedata[8*b +: 8];
        end
      end
    end
  end

  always_comb begin
    cpu_waitrequest = 1'b1;
    read            = 1'b0;
    write           = 1'b0;
    address         = '0;
    writedata       = '0;
    byteenable      = '0;
    case (state_q)
      STATE_IDLE: begin
        cpu_waitrequest = !idle_rd_hit;
      end
      STATE_FETCH: begin
        read       = 1'b1;
        address    = fetch_addr;
        byteenable = 4'hF;
      end
      STATE_WRITE: begin
        write           = 1'b1;
        address         = {cpu_address[31:2], 2'b00};
        writedata       = cpu_writedata;
        byteenable      = cpu_byteenable;
        cpu_waitrequest = waitrequest;
      end
      default: cpu_waitrequest = 1'b1;
    endcase
  end

  assign cpu_readdata = data_q[word_ptr];

`ifdef CACHE_STATS_EN
  logic [31:0] hits_q, misses_q, writes_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hits_q   <= '0;
      misses_q <= '0;
      writes_q <= '0;
    end else begin
      if (idle_rd_hit) begin
        hits_q <= hits_q + 32'd1;
      end
      if ((state_q != STATE_FETCH) && (state_d == STATE_FETCH)) begin
        misses_q <= misses_q + 32'd1;
      end
      if (wr_done) begin
        writes_q <= writes_q + 32'd1;
      end
    end
  end

  assign stat_hits   = hits_q;
  assign stat_misses = misses_q;
  assign stat_writes = writes_q;
`endif

  a_rd_wr_exclusive: assert property (@(posedge clk) disable iff (!rst) !(read && write));

endmodule

// File: tb/tb_mips_cache_controller_param.sv
// Bench for mips_cache_controller_param: table of CPU transactions against a behavioural memory with
// configurable wait states, read data checked through a scoreboard queue, plus a mid-fill reset sequence.
module tb_mips_cache_controller_param;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] cpu_address;
  logic        cpu_read;
  logic        cpu_write;
  logic [31:0] cpu_writedata;
  logic [3:0]  cpu_byteenable;
  logic        cpu_waitrequest;
  logic [31:0] cpu_readdata;
  logic        invalidate;
  logic [31:0] address;
  logic        write;
  logic        read;
  logic [31:0] writedata;
  logic [3:0]  byteenable;
  logic        waitrequest = 1'b0;
  logic [31:0] readdata = '0;
`ifdef CACHE_STATS_EN
  logic [31:0] stat_hits, stat_misses, stat_writes;
`endif

  mips_cache_controller_param #(.LINES(16), .WORDS_PER_LINE(4)) dut (
    .clk(clk), .rst(rst),
    .cpu_address(cpu_address), .cpu_read(cpu_read), .cpu_write(cpu_write),
    .cpu_writedata(cpu_writedata), .cpu_byteenable(cpu_byteenable),
    .cpu_waitrequest(cpu_waitrequest), .cpu_readdata(cpu_readdata),
    .invalidate(invalidate),
    .address(address), .write(write), .read(read), .writedata(writedata),
    .byteenable(byteenable), .waitrequest(waitrequest), .readdata(readdata)
`ifdef CACHE_STATS_EN
    , .stat_hits(stat_hits), .stat_misses(stat_misses), .stat_writes(stat_writes)
`endif
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", nm, act, exp);
  endtask

  // ---------------- behavioural memory ----------------
  logic [31:0] mem [logic [31:0]];
  int          mem_wait = 0;
  int          wcnt = 0;
  int          n_rd = 0;
  logic [31:0] rd_log [$];
  logic [31:0] exp_q  [$];

  function automatic logic [31:0] mem_rd(input logic [31:0] a);
    if (mem.exists(a)) return mem[a];
    return {~a[15:0], a[15:0]} ^ 32'h1357_0000;
  endfunction

  always @(negedge clk) begin
    waitrequest = (read || write) && (wcnt < mem_wait);
    readdata    = mem_rd(address);
  end

  always @(posedge clk) begin
    if (!rst) begin
      wcnt <= 0;
    end else begin
      if (read && !waitrequest) begin
        rd_log.push_back(address);
        n_rd++;
      end
      if (write && !waitrequest) begin
        logic [31:0] m;
        m = mem_rd(address);
        for (int b = 0; b < 4; b++)
          if (byteenable[b]) m[8*b +: 8] = writedata[8*b +: 8];
        mem[address] = m;
      end
      wcnt <= ((read || write) && waitrequest) ? wcnt + 1 : 0;
    end
  end

  // ---------------- transaction table ----------------
  typedef struct {
    bit          is_wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
    int          mwait;
    int          inv_at;     // cycle (from request) to pulse invalidate, -1 = none
    int          exp_stall;  // cycles with cpu_waitrequest=1 before completion
    int          exp_reads;  // memory read beats
  } vec_t;

  function automatic vec_t mk(bit w, logic [31:0] a, logic [31:0] d, logic [3:0] be,
                              int mw, int ia, int st, int rd);
    vec_t v;
    v.is_wr = w; v.addr = a; v.wdata = d; v.be = be; v.mwait = mw;
    v.inv_at = ia; v.exp_stall = st; v.exp_reads = rd;
    return v;
  endfunction

  task automatic run_vec(input vec_t v, input string nm);
    int          stalls = 0;
    int          wcyc   = 0;
    int          rd0;
    bit          done   = 0;
    logic [31:0] exp_d;
    rd_log.delete();
    rd0            = n_rd;
    mem_wait       = v.mwait;
    cpu_address    = v.addr;
    cpu_writedata  = v.wdata;
    cpu_byteenable = v.be;
    cpu_write      = v.is_wr;
    cpu_read       = !v.is_wr;
    if (!v.is_wr) exp_q.push_back(mem_rd({v.addr[31:2], 2'b00}));
    if (v.inv_at >= 0) begin
      fork
        begin
          int ia = v.inv_at;
          repeat (ia) @(posedge clk);
          #1 invalidate = 1'b1;
          @(posedge clk);
          #1 invalidate = 1'b0;
        end
      join_none
    end
    for (int c = 0; c < 200 && !done; c++) begin
      @(negedge clk);
      #1;
      if (v.is_wr && write) begin
        wcyc++;
        chk({nm, "_wr_addr"}, address, {v.addr[31:2], 2'b00});
        chk({nm, "_wr_data"}, writedata, v.wdata);
        chk({nm, "_wr_be"}, 32'(byteenable), 32'(v.be));
      end
      if (!cpu_waitrequest) done = 1;
      else stalls++;
    end
    chk({nm, "_done"}, 32'(done), 32'd1);
    if (!v.is_wr && exp_q.size() > 0) begin
      exp_d = exp_q.pop_front();
      chk({nm, "_rdata"}, cpu_readdata, exp_d);
    end
    @(posedge clk);
    #1;
    cpu_read  = 1'b0;
    cpu_write = 1'b0;
    mem_wait  = 0;
    chk({nm, "_stalls"}, 32'(stalls), 32'(v.exp_stall));
    chk({nm, "_reads"}, 32'(n_rd - rd0), 32'(v.exp_reads));
    if (v.is_wr) chk({nm, "_wr_cycles"}, 32'(wcyc), 32'(v.mwait + 1));
    for (int k = 0; k < rd_log.size(); k++)
      chk({nm, "_fill_addr"}, rd_log[k], {v.addr[31:4], 4'h0} + 32'(4 * (k % 4)));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    vec_t vecs [$];
    vecs.push_back(mk(0, 32'h100, 0, 4'h0, 0, -1, 5, 4));  // cold miss
    vecs.push_back(mk(0, 32'h104, 0, 4'h0, 0, -1, 0, 0));  // hit
    vecs.push_back(mk(1, 32'h108, 32'hAABBCCDD, 4'b0011, 2, -1, 3, 0));
    vecs.push_back(mk(0, 32'h108, 0, 4'h0, 0, -1, 0, 0));  // merged bytes
    vecs.push_back(mk(0, 32'h500, 0, 4'h0, 0, -1, 5, 4));  // conflict
    vecs.push_back(mk(0, 32'h100, 0, 4'h0, 0, -1, 5, 4));
    vecs.push_back(mk(0, 32'h10C, 0, 4'h0, 0, -1, 0, 0));
    vecs.push_back(mk(1, 32'h200, 32'h12345678, 4'hF, 0, -1, 1, 0));  // write miss
    vecs.push_back(mk(0, 32'h104, 0, 4'h0, 0, -1, 0, 0));  // no allocation
    vecs.push_back(mk(0, 32'h200, 0, 4'h0, 0, -1, 5, 4));  // write-through data
    vecs.push_back(mk(0, 32'h3FC, 0, 4'h0, 0, -1, 5, 4));  // last line, last word
    vecs.push_back(mk(0, 32'h3F0, 0, 4'h0, 0, -1, 0, 0));
    vecs.push_back(mk(1, 32'h3F4, 32'h11223344, 4'b1000, 1, -1, 2, 0));
    vecs.push_back(mk(0, 32'h3F4, 0, 4'h0, 0, -1, 0, 0));
    vecs.push_back(mk(0, 32'h104, 0, 4'h0, 1, -1, 9, 4));  // fill with wait states
    vecs.push_back(mk(0, 32'h600, 0, 4'h0, 0, 2, 10, 8));  // invalidate mid-fill: refill
    vecs.push_back(mk(0, 32'h600, 0, 4'h0, 0, -1, 0, 0));
    vecs.push_back(mk(0, 32'h604, 0, 4'h0, 0, 0, 5, 4));   // invalidate beside a hit
    vecs.push_back(mk(0, 32'h608, 0, 4'h0, 0, -1, 0, 0));
    vecs.push_back(mk(1, 32'h604, 32'hCAFEF00D, 4'hF, 0, 0, 1, 0));
    vecs.push_back(mk(0, 32'h604, 0, 4'h0, 0, -1, 5, 4));
    vecs.push_back(mk(1, 32'h60C, 32'h0BADBEEF, 4'b0101, 2, 1, 3, 0));  // pending during write
    vecs.push_back(mk(0, 32'h60C, 0, 4'h0, 0, -1, 5, 4));

    rst = 1'b0; cpu_address = '0; cpu_read = 1'b0; cpu_write = 1'b0;
    cpu_writedata = '0; cpu_byteenable = '0; invalidate = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_read", 32'(read), 32'd0);
    chk("reset_write", 32'(write), 32'd0);
    chk("reset_address", address, 32'd0);
    chk("reset_writedata", writedata, 32'd0);
    chk("reset_byteenable", 32'(byteenable), 32'd0);
    rst = 1'b1;
    @(posedge clk);
    #1;

    for (int i = 0; i < vecs.size(); i++) run_vec(vecs[i], $sformatf("v%0d", i));
    chk("explicit_merge", {16'h0, cpu_readdata[15:0]} & 32'h0, 32'h0);

    // reset during the second fill word
    cpu_address = 32'h700;
    cpu_read    = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #1 rst = 1'b0;
    #1;
    chk("midfill_rst_read", 32'(read), 32'd0);
    chk("midfill_rst_address", address, 32'd0);
    chk("midfill_rst_be", 32'(byteenable), 32'd0);
    cpu_read = 1'b0;
    @(negedge clk);
    rst = 1'b1;
`ifdef CACHE_STATS_EN
    chk("stat_hits_rst", stat_hits, 32'd0);
    chk("stat_misses_rst", stat_misses, 32'd0);
    chk("stat_writes_rst", stat_writes, 32'd0);
`endif
    @(posedge clk);
    #1;
    run_vec(mk(0, 32'h100, 0, 4'h0, 0, -1, 5, 4), "post_rst_100");
    run_vec(mk(0, 32'h104, 0, 4'h0, 0, -1, 0, 0), "post_rst_104");
    run_vec(mk(0, 32'h700, 0, 4'h0, 0, -1, 5, 4), "post_rst_700");

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
